// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with miss handling and branch redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_instr,
  input  logic        imem_busywait,
  output logic [31:0] imem_addr,
  output logic        imem_read,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {BOOT, FETCH, MISS, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] saved_target;
  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;

  // Word-aligned redirect target and sequential next PC (wraps modulo 2^32)
  assign target_aligned = branch_target & ~32'h00000003;
  assign pc_plus4       = pc + 32'd4;
  assign imem_addr      = {pc[31:2], 2'b00};

  // Fetch FSM: PC, saved redirect target and IF/ID register all update here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      saved_target <= 32'h00000000;
      imem_read    <= 1'b0;
      if_id_pc     <= 32'h00000000;
      if_id_pc4    <= 32'h00000000;
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
    end else begin
      // Every state reachable from here issues reads; only reset returns to BOOT
      imem_read <= 1'b1;
      case (state)
        BOOT: begin
          if (branch_taken) pc <= target_aligned;
          state <= FETCH;
        end

        FETCH: begin
          if (branch_taken) begin
            pc          <= target_aligned;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end else if (imem_busywait) begin
            if (!stall) begin
              if_id_instr <= NOP_INSTR;
              if_id_valid <= 1'b0;
            end
            state <= MISS;
          end else if (!stall) begin
            if_id_pc    <= pc;
            if_id_pc4   <= pc_plus4;
            if_id_instr <= imem_instr;
            if_id_valid <= 1'b1;
            pc          <= pc_plus4;
          end
        end

        MISS: begin
          if (branch_taken) begin
            // The outstanding read must complete before the redirect can be issued
            saved_target <= target_aligned;
            if_id_instr  <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            if (imem_busywait) begin
              state <= DRAIN;
            end else begin
              pc    <= target_aligned;
              state <= FETCH;
            end
          end else if (imem_busywait) begin
            if (!stall) begin
              if_id_instr <= NOP_INSTR;
              if_id_valid <= 1'b0;
            end
          end else begin
            // A stalled return is dropped; FETCH re-reads the same PC
            if (!stall) begin
              if_id_pc    <= pc;
              if_id_pc4   <= pc_plus4;
              if_id_instr <= imem_instr;
              if_id_valid <= 1'b1;
              pc          <= pc_plus4;
            end
            state <= FETCH;
          end
        end

        DRAIN: begin
          // The stale word is discarded; the newest redirect wins
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
          if (branch_taken) saved_target <= target_aligned;
          if (!imem_busywait) begin
            pc    <= branch_taken ? target_aligned : saved_target;
            state <= FETCH;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_instr;
  logic        imem_busywait;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_instr    (imem_instr),
    .imem_busywait (imem_busywait),
    .imem_addr     (imem_addr),
    .imem_read     (imem_read),
    .if_id_pc      (if_id_pc),
    .if_id_pc4     (if_id_pc4),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Instruction memory: word depends on the address so wrong PCs show up
  assign imem_instr = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the IF/ID state expected after the next edge
  task automatic step(input logic st, input logic bt, input logic [31:0] tgt, input logic busy,
                      input logic [31:0] e_addr, input logic e_valid,
                      input logic [31:0] e_pc, input logic [31:0] e_pc4);
    exp_t e;
    stall         = st;
    branch_taken  = bt;
    branch_target = tgt;
    imem_busywait = busy;
    e.addr  = e_addr;
    e.valid = e_valid;
    e.pc    = e_pc;
    e.pc4   = e_pc4;
    e.instr = e_valid ? mem_word(e_pc) : NOP;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_read"},  {31'd0, imem_read},   32'd0);
    chk({tag, "_addr"},  imem_addr,            32'h00000000);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_instr"}, if_id_instr,          NOP);
    chk({tag, "_pc"},    if_id_pc,             32'h00000000);
    chk({tag, "_pc4"},   if_id_pc4,            32'h00000000);
  endtask

  // Monitor: compare each queued expectation just after the clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_read", {31'd0, imem_read},   32'd1);
        chk("imem_addr", imem_addr,            e.addr);
        chk("valid",     {31'd0, if_id_valid}, {31'd0, e.valid});
        chk("pc",        if_id_pc,             e.pc);
        chk("pc4",       if_id_pc4,            e.pc4);
        chk("instr",     if_id_instr,          e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_busywait = 1'b0;
    #12;
    chk_reset_state("rst");
    @(negedge clk);
    reset = 1'b1;

    // Boot then sequential fetch
    step(0, 0, 32'h0, 0, 32'h00000000, 0, 32'h00000000, 32'h00000000);
    step(0, 0, 32'h0, 0, 32'h00000004, 1, 32'h00000000, 32'h00000004);
    step(0, 0, 32'h0, 0, 32'h00000008, 1, 32'h00000004, 32'h00000008);
    step(0, 0, 32'h0, 0, 32'h0000000C, 1, 32'h00000008, 32'h0000000C);
    step(0, 0, 32'h0, 0, 32'h00000010, 1, 32'h0000000C, 32'h00000010);
    // Three-cycle miss at 0x10
    step(0, 0, 32'h0, 1, 32'h00000010, 0, 32'h0000000C, 32'h00000010);
    step(0, 0, 32'h0, 1, 32'h00000010, 0, 32'h0000000C, 32'h00000010);
    step(0, 0, 32'h0, 1, 32'h00000010, 0, 32'h0000000C, 32'h00000010);
    step(0, 0, 32'h0, 0, 32'h00000014, 1, 32'h00000010, 32'h00000014);
    step(0, 0, 32'h0, 0, 32'h00000018, 1, 32'h00000014, 32'h00000018);
    step(0, 0, 32'h0, 0, 32'h0000001C, 1, 32'h00000018, 32'h0000001C);
    step(0, 0, 32'h0, 0, 32'h00000020, 1, 32'h0000001C, 32'h00000020);
    // Branch to 0x103 under stall at PC 0x20
    step(1, 1, 32'h00000103, 0, 32'h00000100, 0, 32'h0000001C, 32'h00000020);
    step(1, 0, 32'h0, 0, 32'h00000100, 0, 32'h0000001C, 32'h00000020);
    step(0, 0, 32'h0, 0, 32'h00000104, 1, 32'h00000100, 32'h00000104);
    // Miss under stall holds IF/ID, stalled return is refetched
    step(1, 0, 32'h0, 1, 32'h00000104, 1, 32'h00000100, 32'h00000104);
    step(1, 0, 32'h0, 0, 32'h00000104, 1, 32'h00000100, 32'h00000104);
    step(0, 0, 32'h0, 0, 32'h00000108, 1, 32'h00000104, 32'h00000108);
    // Four-cycle miss with redirect at its first cycle; second redirect overwrites target
    step(0, 0, 32'h0, 1, 32'h00000108, 0, 32'h00000104, 32'h00000108);
    step(0, 1, 32'h00000300, 1, 32'h00000108, 0, 32'h00000104, 32'h00000108);
    step(0, 1, 32'h00000202, 1, 32'h00000108, 0, 32'h00000104, 32'h00000108);
    step(0, 0, 32'h0, 1, 32'h00000108, 0, 32'h00000104, 32'h00000108);
    step(0, 0, 32'h0, 0, 32'h00000200, 0, 32'h00000104, 32'h00000108);
    step(0, 0, 32'h0, 0, 32'h00000204, 1, 32'h00000200, 32'h00000204);
    // Redirect in the cycle the miss resolves, to the top word
    step(0, 0, 32'h0, 1, 32'h00000204, 0, 32'h00000200, 32'h00000204);
    step(0, 1, 32'hFFFFFFFE, 0, 32'hFFFFFFFC, 0, 32'h00000200, 32'h00000204);
    // Wrap-around of PC and PC+4
    step(0, 0, 32'h0, 0, 32'h00000000, 1, 32'hFFFFFFFC, 32'h00000000);
    step(0, 0, 32'h0, 0, 32'h00000004, 1, 32'h00000000, 32'h00000004);
    // Enter MISS, then pulse reset between edges
    step(0, 0, 32'h0, 1, 32'h00000004, 0, 32'h00000000, 32'h00000004);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_state("midrst");
    #1;
    reset         = 1'b1;
    imem_busywait = 1'b0;
    // Redirect while in BOOT, then fetch from the redirected PC
    step(0, 1, 32'h00000040, 0, 32'h00000040, 0, 32'h00000000, 32'h00000000);
    step(0, 0, 32'h0, 0, 32'h00000044, 1, 32'h00000040, 32'h00000044);
    step(0, 0, 32'h0, 0, 32'h00000048, 1, 32'h00000044, 32'h00000048);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
